// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, FSM state type and bin-order helper for the FFT controller
package fft_pkg;

    localparam int FFT_N    = 16;
    localparam int FFT_LOGN = 4;
    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Radix-2 results come back in bit-reversed slot order.
    function automatic logic [FFT_LOGN-1:0] bitrev4(input logic [FFT_LOGN-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// rtl/fft_ctrl_if.sv - sample input and result output handshakes of the FFT controller
interface fft_ctrl_if;

    logic                              in_valid;
    logic                              in_ready;
    logic [fft_pkg::SAMPLE_W-1:0]      in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [fft_pkg::SAMPLE_W-1:0]      out_data;
    logic [fft_pkg::FFT_LOGN-1:0]      out_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );

endinterface

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - 16x32 frame register file, indexed write, flattened 512-bit read
module fft_frame_buf
    import fft_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [FFT_LOGN-1:0]         waddr,
    input  logic [SAMPLE_W-1:0]         wdata,
    output logic [FFT_N*SAMPLE_W-1:0]   rdata
);

    logic [SAMPLE_W-1:0] mem [FFT_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar g = 0; g < FFT_N; g++) begin : g_rd
        assign rdata[g*SAMPLE_W +: SAMPLE_W] = mem[g];
    end

endmodule

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - FFT frame controller: fill, wait on datapath, drain in bin order; FFT_CTRL_OVERLAP_EN fills next frame during drain
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int DP_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    fft_ctrl_if.slave                   s,
    output logic [FFT_N*SAMPLE_W-1:0]   dp_data_out,
    input  logic [FFT_N*SAMPLE_W-1:0]   dp_data_in,
    output logic                        frame_done,
    output logic                        busy
);

    localparam logic [1:0] LAT_M1 = 2'(DP_LAT - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [FFT_LOGN-1:0]         fill_cnt;
    logic [1:0]                  wait_cnt;
    logic [FFT_LOGN-1:0]         k;
    logic                        next_full;
    logic [FFT_N*SAMPLE_W-1:0]   result;

    logic accept;
    logic last_in;
    logic hs;
    logic last_out;
    logic capture;

    assign accept   = s.in_valid && s.in_ready;
    assign last_in  = accept && (fill_cnt == 4'(FFT_N - 1));
    assign hs       = s.out_valid && s.out_ready;
    assign last_out = hs && (k == 4'(FFT_N - 1));
    assign capture  = (state == WAIT) && (wait_cnt == LAT_M1);

    fft_frame_buf u_frame_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (fill_cnt),
        .wdata (s.in_data),
        .rdata (dp_data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (last_in) state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = DRAIN;
            DRAIN: begin
                // A frame completing on the final handshake still counts as buffered.
                if (last_out) state_nxt = (next_full || last_in) ? WAIT : FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        s.out_idx   = k;
        s.out_data  = '0;
        frame_done  = 1'b0;
        busy        = (state != FILL) || (fill_cnt != '0);
`ifdef FFT_CTRL_OVERLAP_EN
        s.in_ready  = (state == FILL) || ((state == DRAIN) && !next_full);
`else
        s.in_ready  = (state == FILL);
`endif
        if (state == DRAIN) begin
            s.out_valid = 1'b1;
            s.out_data  = result[SAMPLE_W*int'(bitrev4(k)) +: SAMPLE_W];
            frame_done  = last_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt  <= '0;
            wait_cnt  <= '0;
            k         <= '0;
            next_full <= 1'b0;
            result    <= '0;
        end else begin
            if (accept) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (!capture) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                result <= dp_data_in;
            end
            if (hs) begin
                k <= k + 1'b1;
            end
            // Set when the next frame is complete before the drain finishes.
            if (last_out) begin
                next_full <= 1'b0;
            end else if ((state == DRAIN) && last_in) begin
                next_full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter DP_LAT, default 1, legal range 1..4. Number of cycles from a stable frame on dp_data_out to a valid result on dp_data_in.
REQ-002 Port clk, input, 1 bit. Single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit. Synchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit. An input sample is offered.
REQ-005 Port in_ready, output, 1 bit. The controller can accept a sample this cycle.
REQ-006 Port in_data, input, 32 bits. One complex sample, {real[15:0], imag[15:0]}, both signed Q8.8.
REQ-007 Port dp_data_out, output, 512 bits. Frame buffer to the butterfly datapath; slot n occupies bits [32n+31:32n].
REQ-008 Port dp_data_in, input, 512 bits. Result frame returned by the datapath, using the same slot layout.
REQ-009 Port out_valid, output, 1 bit. A result sample is offered.
REQ-010 Port out_ready, input, 1 bit. The consumer accepts the offered result.
REQ-011 Port out_data, output, 32 bits. Result sample, {real, imag}.
REQ-012 Port out_idx, output, 4 bits. Frequency bin k of out_data.
REQ-013 Port frame_done, output, 1 bit. One-cycle pulse on the last result handshake of a frame.
REQ-014 Port busy, output, 1 bit. High when the state is not FILL, or when fill_cnt is not 0.

Function
REQ-015 FSM states and transitions:
- FILL -> WAIT when the 16th sample is accepted.
- WAIT -> DRAIN at the result capture.
- DRAIN -> FILL or WAIT after the 16th result handshake.
REQ-016 A sample is accepted when in_valid && in_ready.
- The sample is written to slot fill_cnt, and fill_cnt increments (range 0..15, wraps to 0).
REQ-017 dp_data_out reflects the frame buffer contents at all times and is held constant throughout WAIT.
REQ-018 WAIT counter behaviour:
- The counter clears on WAIT entry.
- dp_data_in is captured into the 512-bit result register on the edge where the counter equals DP_LAT-1.
- The FSM enters DRAIN on that same edge.
REQ-019 Latency: out_valid first rises DP_LAT+1 cycles after the cycle in which the 16th sample is accepted.
REQ-020 DRAIN output mapping: out_idx = k and out_data = result slot bitrev4(k), for k = 0..15 in order.
- k advances only on out_valid && out_ready.
REQ-021 out_valid, out_data and out_idx shall stay stable while out_valid && !out_ready.
REQ-022 No bubbles in DRAIN: out_valid stays high continuously from DRAIN entry until the 16th handshake.
REQ-023 The result register is written only at capture; the datapath is never sampled in any other state.
REQ-024 The arithmetic path is pass-through: the controller performs no scaling, rounding or sign extension on any sample.
REQ-025 End of DRAIN: the FSM goes to WAIT if a full next frame (16 samples) is already buffered, otherwise to FILL.
- A 16th sample accepted in the same cycle as the 16th result handshake also counts as a full frame, so the FSM goes to WAIT.

Reset
REQ-026 While rst is high at an edge:
- state = FILL; fill_cnt, the WAIT counter and k are all 0.
- in_ready = 1; out_valid = 0, frame_done = 0, busy = 0; out_idx = 0, out_data = 0.
- Frame buffer and result register = 0.
REQ-027 A reset asserted mid-frame or mid-drain discards all partial input and any undrained results; no frame_done pulse is produced.

Configuration
REQ-028 Macro FFT_CTRL_OVERLAP_EN selects whether the next frame can be filled during DRAIN.
- Defined: in_ready = 1 in FILL, and also in DRAIN while fill_cnt has not yet reached 16 buffered samples. Filling the next frame overlaps the drain; this is safe because the results are already captured.
- Undefined: in_ready = 1 only in FILL; DRAIN always returns to FILL.
REQ-029 In both configurations in_ready shall be 0 throughout WAIT.

Structure
REQ-030 Shared package fft_pkg shall contain:
- FFT_N = 16, FFT_LOGN = 4, SAMPLE_W = 32.
- The state enum {FILL, WAIT, DRAIN}.
- The bitrev4 function.
REQ-031 Sub-module fft_frame_buf: a 16x32 register file with an indexed write port and a flattened 512-bit read bus. It is instantiated for the frame buffer only.

Verification
REQ-032 Benches use an identity datapath stub (dp_data_in = dp_data_out, delayed DP_LAT-1 cycles).
REQ-033 Identity scenario: DP_LAT=1, inputs 0x0000_0000..0x0000_000F back-to-back.
- Expect out_data sequence 0,8,4,C,2,A,6,E,1,9,5,D,3,B,7,F.
- Expect out_idx 0..15.
- Expect the first out_valid 2 cycles after the 16th accept.
- Expect frame_done on the final handshake.
REQ-034 Backpressure scenario: out_ready is toggled 1,0,0,1 repeatedly.
- Expect out_data/out_idx to hold while stalled.
- Expect exactly 16 handshakes and the same sequence as REQ-033.
REQ-035 DP_LAT=3 scenario: the stub delays by 2 cycles.
- Expect capture on the 3rd WAIT edge.
- Expect the first out_valid 4 cycles after the 16th accept.
- Expect in_ready=0 throughout WAIT.
REQ-036 Overlap scenario (FFT_CTRL_OVERLAP_EN defined): feed frame B (values 0x0001_0000+n) during the drain of frame A, with B's 16th accept on A's final handshake.
- Expect WAIT next, then B's results 0x0001_0000, 0x0001_0008, ...
- Undefined build: expect in_ready=0 throughout DRAIN.
REQ-037 Reset scenario: assert rst for 1 cycle after the 5th result handshake.
- Expect out_valid=0 and in_ready=1 next cycle, no frame_done, busy=0.
- Expect a following fresh frame to reproduce the REQ-033 sequence.
